// File: rtl/rv32_decode_stage_hs.sv
// RV32 decode stage: decodes fetched instructions, resolves source operands against
// writeback forwarding ports and buffers the results in a small snooping output queue.

package rv32_decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } decoded_instr_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // bit30 selects SUB only for register-register ops; SRA/SRL use it in both forms.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic bit30,
                                               input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decoded_instr_t decode_instr(input logic [31:0] instr);
    decoded_instr_t d;
    logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    d        = '0;
    d.alu_op = ALU_ADD;
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.funct7 = instr[31:25];
    case (instr[6:0])
      OPC_LUI:    begin d.imm = imm_u; d.use_imm = 1'b1; d.alu_op = ALU_PASS_B; d.reg_write = 1'b1; end
      OPC_AUIPC:  begin d.imm = imm_u; d.use_imm = 1'b1; d.use_pc = 1'b1; d.reg_write = 1'b1; end
      OPC_JAL:    begin d.imm = imm_j; d.use_pc = 1'b1; d.jump = 1'b1; d.reg_write = 1'b1; end
      OPC_JALR:   begin d.imm = imm_i; d.use_imm = 1'b1; d.jump = 1'b1; d.reg_write = 1'b1; end
      OPC_BRANCH: begin d.imm = imm_b; d.branch = 1'b1; d.alu_op = ALU_SUB; end
      OPC_LOAD:   begin d.imm = imm_i; d.use_imm = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; end
      OPC_STORE:  begin d.imm = imm_s; d.use_imm = 1'b1; d.mem_write = 1'b1; end
      OPC_OP_IMM: begin
        d.imm       = imm_i;
        d.use_imm   = 1'b1;
        d.reg_write = 1'b1;
        d.alu_op    = alu_from_funct3(instr[14:12], instr[30], 1'b0);
      end
      OPC_OP: begin
        d.reg_write = 1'b1;
        d.alu_op    = alu_from_funct3(instr[14:12], instr[30], 1'b1);
      end
      OPC_FENCE, OPC_SYSTEM: ;  // no register or ALU effect at this stage
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// Pure combinational decoder; set_nop forces the canonical NOP decode.
module rv32_instr_decoder
  import rv32_decode_pkg::*;
(
  input  logic           set_nop,
  input  logic [31:0]    instr,
  output decoded_instr_t decoded
);
  assign decoded = decode_instr(set_nop ? NOP_INSTR : instr);
endmodule

module rv32_decode_stage_hs
  import rv32_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 2,
  parameter int SKID_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_instr,
  input  logic                    flush,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  input  logic [XLEN-1:0]         reg1,
  input  logic [XLEN-1:0]         reg2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_instr,
  output decoded_instr_t          out_decoded,
  output logic [XLEN-1:0]         out_reg1,
  output logic [XLEN-1:0]         out_reg2
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    decoded_instr_t  dec;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: '0, instr: '0, dec: decode_instr(NOP_INSTR),
                                   reg1: '0, reg2: '0};

  entry_t               entry_q [SKID_DEPTH];
  entry_t               entry_d [SKID_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  decoded_instr_t       in_dec;
  logic                 push, pop;

  rv32_instr_decoder u_decoder (
    .set_nop (~resetn),
    .instr   (in_instr),
    .decoded (in_dec)
  );

  // Lowest-index matching forwarding port wins; x0 always reads as zero.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] dflt);
    logic [XLEN-1:0] val;
    logic            hit;
    val = dflt;
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs)) begin
        val = fwd_data[i*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
    if (rs == 5'd0) val = '0;
    return val;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic slot_held(input int idx);
    int off;
    off = idx - int'(rd_ptr_q);
    if (off < 0) off += SKID_DEPTH;
    return off < int'(count_q);
  endfunction

  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign in_ready  = (count_q < CNT_W'(SKID_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc      = entry_q[rd_ptr_q].pc;
  assign out_instr   = entry_q[rd_ptr_q].instr;
  assign out_decoded = entry_q[rd_ptr_q].dec;
  assign out_reg1    = entry_q[rd_ptr_q].reg1;
  assign out_reg2    = entry_q[rd_ptr_q].reg2;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < SKID_DEPTH; i++) begin
      if (slot_held(i)) begin
        entry_d[i].reg1 = resolve(entry_q[i].instr[19:15], entry_q[i].reg1);
        entry_d[i].reg2 = resolve(entry_q[i].instr[24:20], entry_q[i].reg2);
      end
    end

    if (push) begin
      entry_d[wr_ptr_q].pc    = in_pc;
      entry_d[wr_ptr_q].instr = in_instr;
      entry_d[wr_ptr_q].dec   = in_dec;
      entry_d[wr_ptr_q].reg1  = resolve(rs1, reg1);
      entry_d[wr_ptr_q].reg2  = resolve(rs2, reg2);
      wr_ptr_d                = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: queue storage is reset as well, so the idle head shows a clean NOP payload.
      for (int i = 0; i < SKID_DEPTH; i++) entry_q[i] <= ENTRY_RST;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      entry_q  <= entry_d;
    end
  end

endmodule
